pci_master_ctrl: RTL
====================

Name: pci_master_ctrl

Overview:
- PCI initiator-side bus sequencer; the counterpart of the slave TRDY/DEVSEL logic.
- Accepts a single burst request from a local host and drives FRAME#, IRDY#, C/BE# and AD for the address and data phases.
- Samples DEVSEL#, TRDY# and STOP# from the target, and handles normal completion, target disconnect/retry and master abort.
- All bus control outputs are active-low; 1 means deasserted.

Parameters:
- LEN_W, 4, width of burst length field; a burst is len+1 transfers (1..2^LEN_W).
- DEVSEL_TIMEOUT, 5, clocks after the address phase without DEVSEL# before master abort.

Ports:
- clk  in  1  bus clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  start-transaction strobe; accepted only in IDLE.
- cmd  in  4  PCI command; cmd[0]=1 is write, 0 is read; latched on accept.
- addr  in  32  start address; latched on accept.
- len  in  LEN_W  transfers minus one; latched on accept.
- byte_en_n  in  4  C/BE# value for data phases.
- wdata  in  32  write data; the host advances it on the edge where wdata_ack=1.
- devsel_n  in  1  target DEVSEL#.
- trdy_n  in  1  target TRDY#.
- stop_n  in  1  target STOP#.
- frame_n  out  1  FRAME#.
- irdy_n  out  1  IRDY#.
- cbe_n  out  4  C/BE#.
- ad_out  out  32  AD drive value.
- ad_oe  out  1  AD output enable.
- wdata_ack  out  1  combinational; 1 when a write data phase completes with data this cycle.
- rdata  out  32  captured read data.
- rdata_valid  out  1  one-cycle pulse with rdata.
- ad_in  in  32  AD bus sampled value.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- status  out  2  valid with done: 00 normal, 01 target-terminated early, 10 master abort.
- xfer_count  out  LEN_W+1  transfers completed with data in the current/last transaction.

Behaviour:
- Reset values (applied on any clk edge with rst=1, including mid-transaction):
  - frame_n=1, irdy_n=1, cbe_n=4'hF, ad_oe=0.
  - done=0, rdata_valid=0, status=00, xfer_count=0.
  - State returns to IDLE.
- States: IDLE, ADDR, DATA, ABORT, TURN.
- IDLE:
  - Outputs deasserted.
  - req=1: latch cmd/addr/len, clear xfer_count, go to ADDR next edge.
- ADDR (exactly 1 clock):
  - frame_n=0, irdy_n=1, cbe_n=cmd, ad_out=addr, ad_oe=1.
  - Load remaining=len+1, clear devsel timer, go to DATA.
- DATA:
  - irdy_n=0 always (no master wait states), cbe_n=byte_en_n.
  - Write: ad_oe=1, ad_out=wdata. Read: ad_oe=0.
  - frame_n=0 while remaining>1; frame_n=1 when remaining==1 (last phase) or after a stop.
- Data phase completion: irdy_n=0 and (trdy_n=0 or stop_n=0).
- With-data transfer: irdy_n=0 and trdy_n=0.
  - Increment xfer_count, decrement remaining.
  - Read: rdata<=ad_in, rdata_valid=1 next cycle.
  - Write: wdata_ack=1 in the same cycle.
- Completion with frame_n=1: go to TURN.
  - status=00 if every requested transfer completed.
  - status=01 if stop_n=0 ended the transaction early.
- stop_n=0 sampled while frame_n=0: frame_n<=1 next cycle and stay in DATA until the next completion.
  - Retry (no data) therefore gives xfer_count=0, status=01.
- Master abort:
  - The devsel timer counts DATA clocks while devsel_n=1 and no DEVSEL has yet been seen.
  - Once devsel_n=0 is sampled, the timer stops.
  - If the timer reaches DEVSEL_TIMEOUT, go to ABORT: frame_n=1, irdy_n=0 for 1 clock.
  - Then go to TURN with status=10.
  - trdy_n/stop_n are ignored before DEVSEL is seen.
- TURN (1 clock):
  - frame_n=1, irdy_n=1, ad_oe=0, cbe_n=F.
  - done=1, busy=1; go to IDLE.
- req while busy: ignored, not queued.
- Single transfer (len=0): frame_n=1 from the first DATA clock.
- Length arithmetic: remaining is LEN_W+1 bits; len all-ones gives 2^LEN_W transfers, no overflow.

Test Plan:
- Write burst, cmd=4'h7, addr=32'h1000, len=3, target DEVSEL on 1st DATA clock, TRDY every clock:
  - One ADDR clock with ad_out=1000, then 4 DATA clocks.
  - frame_n rises on the 4th DATA clock; 4 wdata_ack pulses.
  - done with status=00, xfer_count=4.
- Read, cmd=4'h6, len=1, TRDY withheld 2 clocks then asserted twice:
  - irdy_n held low throughout; ad_oe=0 in DATA.
  - 2 rdata_valid pulses carrying ad_in values; status=00.
- No target (devsel_n stuck 1), len=2:
  - ABORT entered at DATA clock 5, then TURN.
  - done with status=10, xfer_count=0.
- Disconnect, len=7, stop_n=0 with trdy_n=0 on the 3rd transfer:
  - frame_n=1 next clock; transaction ends after the following completion.
  - status=01, xfer_count less than 8.
- Retry: stop_n=0, trdy_n=1 on the first DATA clock:
  - Ends with xfer_count=0, status=01, zero wdata_ack pulses.
- rst=1 asserted mid-DATA:
  - Next edge frame_n=1, irdy_n=1, ad_oe=0, busy=0.
  - A req after rst deasserts starts a clean ADDR phase.

Source files
------------

// File: rtl/pci_master_ctrl.sv
// PCI initiator bus sequencer: runs one burst (address phase plus data phases) per host
// request. Handles normal completion, target disconnect/retry and master abort.
module pci_master_ctrl #(
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned DEVSEL_TIMEOUT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [3:0]       cmd,
    input  logic [31:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       byte_en_n,
    input  logic [31:0]      wdata,
    input  logic             devsel_n,
    input  logic             trdy_n,
    input  logic             stop_n,
    output logic             frame_n,
    output logic             irdy_n,
    output logic [3:0]       cbe_n,
    output logic [31:0]      ad_out,
    output logic             ad_oe,
    output logic             wdata_ack,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    input  logic [31:0]      ad_in,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [LEN_W:0]   xfer_count
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned TMR_W = $clog2(DEVSEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ABORT,
        S_TURN
    } state_t;

    state_t             state_q;
    logic               is_write_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [TMR_W-1:0]   timer_q;
    logic               seen_q;
    logic               frame_q;
    logic               irdy_q;
    logic [3:0]         cbe_q;
    logic [31:0]        ad_q;
    logic               oe_q;
    logic [31:0]        rdata_q;
    logic               rvalid_q;
    logic               busy_q;
    logic               done_q;
    logic [1:0]         status_q;
    logic [CNT_W-1:0]   xfer_q;

    logic               in_data_c;
    logic               seen_c;
    logic               xfer_c;
    logic               cmpl_c;
    logic [CNT_W-1:0]   rem_after_c;
    logic [TMR_W-1:0]   timer_inc_c;
    logic               timer_hit_c;

    // Data-phase qualifiers; trdy/stop only count once the target has claimed the cycle.
    always_comb begin
        in_data_c   = (state_q == S_DATA);
        seen_c      = seen_q | ~devsel_n;
        xfer_c      = in_data_c & seen_c & ~trdy_n;
        cmpl_c      = in_data_c & seen_c & (~trdy_n | ~stop_n);
        rem_after_c = remaining_q;
        if (xfer_c) begin
            rem_after_c = remaining_q - CNT_W'(1);
        end
        timer_inc_c = timer_q + TMR_W'(1);
        timer_hit_c = (timer_inc_c == TMR_W'(DEVSEL_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            len_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            seen_q      <= 1'b0;
            frame_q     <= 1'b1;
            irdy_q      <= 1'b1;
            cbe_q       <= 4'hF;
            ad_q        <= '0;
            oe_q        <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 2'b00;
            xfer_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q    <= S_ADDR;
                        is_write_q <= cmd[0];
                        len_q      <= len;
                        xfer_q     <= '0;
                        status_q   <= 2'b00;
                        busy_q     <= 1'b1;
                        frame_q    <= 1'b0;
                        irdy_q     <= 1'b1;
                        cbe_q      <= cmd;
                        ad_q       <= addr;
                        oe_q       <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state_q     <= S_DATA;
                    remaining_q <= CNT_W'(len_q) + CNT_W'(1);
                    timer_q     <= '0;
                    seen_q      <= 1'b0;
                    frame_q     <= (len_q == '0);
                    irdy_q      <= 1'b0;
                    cbe_q       <= byte_en_n;
                    oe_q        <= is_write_q;
                end
                S_DATA: begin
                    seen_q <= seen_c;
                    if (!seen_c) begin
                        timer_q <= timer_inc_c;
                        if (timer_hit_c) begin
                            state_q <= S_ABORT;
                            frame_q <= 1'b1;
                        end
                    end else begin
                        if (xfer_c) begin
                            xfer_q      <= xfer_q + CNT_W'(1);
                            remaining_q <= rem_after_c;
                            if (!is_write_q) begin
                                rdata_q  <= ad_in;
                                rvalid_q <= 1'b1;
                            end
                        end
                        // A completion with FRAME# already high is the final phase.
                        if (cmpl_c) begin
                            if (frame_q) begin
                                state_q  <= S_TURN;
                                frame_q  <= 1'b1;
                                irdy_q   <= 1'b1;
                                cbe_q    <= 4'hF;
                                oe_q     <= 1'b0;
                                done_q   <= 1'b1;
                                status_q <= (rem_after_c == '0) ? 2'b00 : 2'b01;
                            end else begin
                                frame_q <= ~stop_n | (rem_after_c == CNT_W'(1));
                            end
                        end
                    end
                end
                S_ABORT: begin
                    state_q  <= S_TURN;
                    frame_q  <= 1'b1;
                    irdy_q   <= 1'b1;
                    cbe_q    <= 4'hF;
                    oe_q     <= 1'b0;
                    done_q   <= 1'b1;
                    status_q <= 2'b10;
                end
                S_TURN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write data and byte enables pass straight through during data phases so the host's
    // advance on wdata_ack lands on the very next phase.
    assign ad_out      = (in_data_c || state_q == S_ABORT) ? wdata : ad_q;
    assign cbe_n       = in_data_c ? byte_en_n : cbe_q;
    assign wdata_ack   = xfer_c & is_write_q;
    assign frame_n     = frame_q;
    assign irdy_n      = irdy_q;
    assign ad_oe       = oe_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign xfer_count  = xfer_q;

endmodule
